// File: rtl/fp_addsub_unit.sv
// Multi-cycle IEEE-754 single/double add/subtract unit (RNE, denormals flushed).
// Single operands/results live in bits [63:32]; the datapath is shared, with single
// significands left-aligned in the 53-bit field so only the rounding point differs.
module fp_addsub_unit #(
    parameter logic [5:0] FP_OP     = 6'b111111,
    parameter logic [4:0] COP_S     = 5'b10000,
    parameter logic [4:0] COP_D     = 5'b10001,
    parameter logic [5:0] FUNCT_ADD = 6'b000000,
    parameter logic [5:0] FUNCT_SUB = 6'b000001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  op,
    input  logic [4:0]  cop,
    input  logic [5:0]  funct,
    input  logic [63:0] read_f_data1,
    input  logic [63:0] read_f_data2,
    output logic        busy,
    output logic        done,
    output logic [63:0] write_data_f,
    output logic        overflow,
    output logic        invalid
);

    typedef enum logic [2:0] {
        IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, PACK, DONE
    } state_t;

    state_t state;

    // captured request
    logic [63:0] a_raw, b_raw;
    logic        dbl, sub;

    // unpack stage
    logic        u_sa, u_sb;
    logic [10:0] u_ea, u_eb;
    logic [52:0] u_ma, u_mb;
    logic        spec_vld, spec_inv;
    logic [63:0] spec_res;

    // align stage
    logic        x_sign, x_sub;
    logic [10:0] x_exp;
    logic [55:0] x_big, x_small;

    // add stage
    logic        s_sign;
    logic [10:0] s_exp;
    logic [56:0] s_sum;

    // normalise stage
    logic               n_sign, n_zero;
    logic signed [12:0] n_exp;
    logic [55:0]        n_mant;

    // round stage
    logic               r_sign, r_zero;
    logic signed [12:0] r_exp;
    logic [51:0]        r_frac;

    // ---------------- unpack / classify ----------------
    logic        c_sa, c_sb, c_za, c_zb, c_ia, c_ib, c_na, c_nb;
    logic [10:0] c_ea, c_eb, c_emax;
    logic [51:0] c_fa, c_fb;
    logic        c_spec, c_inv;
    logic [63:0] c_res;

    function automatic logic [63:0] inf_of(input logic s, input logic d);
        return d ? {s, 11'h7FF, 52'b0} : {s, 8'hFF, 55'b0};
    endfunction

    always_comb begin
        c_emax = dbl ? 11'h7FF : 11'h0FF;
        c_sa   = a_raw[63];
        c_sb   = b_raw[63] ^ sub;
        if (dbl) begin
            c_ea = a_raw[62:52];
            c_fa = a_raw[51:0];
            c_eb = b_raw[62:52];
            c_fb = b_raw[51:0];
        end else begin
            c_ea = {3'b000, a_raw[62:55]};
            c_fa = {a_raw[54:32], 29'b0};
            c_eb = {3'b000, b_raw[62:55]};
            c_fb = {b_raw[54:32], 29'b0};
        end
        c_za = (c_ea == '0);
        c_zb = (c_eb == '0);
        c_ia = (c_ea == c_emax) && (c_fa == '0);
        c_ib = (c_eb == c_emax) && (c_fb == '0);
        c_na = (c_ea == c_emax) && (c_fa != '0);
        c_nb = (c_eb == c_emax) && (c_fb != '0);

        c_spec = 1'b1;
        c_inv  = 1'b0;
        c_res  = '0;
        if (c_na || c_nb || (c_ia && c_ib && (c_sa != c_sb))) begin
            c_inv = 1'b1;
            c_res = dbl ? 64'h7FF8_0000_0000_0000 : 64'h7FC0_0000_0000_0000;
        end else if (c_ia) begin
            c_res = inf_of(c_sa, dbl);
        end else if (c_ib) begin
            c_res = inf_of(c_sb, dbl);
        end else if (c_za && c_zb) begin
            c_res = {c_sa & c_sb, 63'b0};
        end else begin
            c_spec = 1'b0;
        end
    end

    // ---------------- align ----------------
    logic        al_swap;
    logic [10:0] al_diff;
    logic [5:0]  al_sh;
    logic [52:0] al_mb, al_ms;
    logic [55:0] al_ext, al_shifted;
    logic        al_stk;

    always_comb begin
        al_swap = {u_eb, u_mb} > {u_ea, u_ma};
        al_mb   = al_swap ? u_mb : u_ma;
        al_ms   = al_swap ? u_ma : u_mb;
        al_diff = al_swap ? (u_eb - u_ea) : (u_ea - u_eb);
        al_sh   = (al_diff > 11'd56) ? 6'd56 : al_diff[5:0];
        al_ext  = {al_ms, 3'b000};
        // shifts past the guard/round/sticky window leave only a sticky bit
        if (al_sh >= 6'd56) begin
            al_shifted = '0;
            al_stk     = |al_ms;
        end else begin
            al_shifted = al_ext >> al_sh;
            al_stk     = |(al_ext & ~({56{1'b1}} << al_sh));
        end
    end

    // ---------------- normalise ----------------
    logic [5:0]  nz_lz;
    logic [55:0] nz_shifted;

    always_comb begin
        nz_lz = '0;
        for (int unsigned i = 0; i < 56; i++) begin
            if (s_sum[i]) nz_lz = 6'(55 - i);
        end
        nz_shifted = s_sum[55:0] << nz_lz;
    end

    // ---------------- round ----------------
    logic [52:0] rd_m, rd_mt, rd_inc;
    logic        rd_lsb, rd_g, rd_st, rd_up;
    logic [53:0] rd_sum;

    always_comb begin
        rd_m = n_mant[55:3];
        if (dbl) begin
            rd_lsb = rd_m[0];
            rd_g   = n_mant[2];
            rd_st  = |n_mant[1:0];
            rd_mt  = rd_m;
            rd_inc = 53'd1;
        end else begin
            rd_lsb = rd_m[29];
            rd_g   = rd_m[28];
            rd_st  = (|rd_m[27:0]) | (|n_mant[2:0]);
            rd_mt  = {rd_m[52:29], 29'b0};
            rd_inc = 53'd1 << 29;
        end
        rd_up  = rd_g & (rd_st | rd_lsb);
        rd_sum = {1'b0, rd_mt} + {1'b0, (rd_up ? rd_inc : 53'd0)};
    end

    // ---------------- pack ----------------
    logic               pk_ovf, pk_inv;
    logic [63:0]        pk_res;
    logic signed [12:0] pk_emax;

    always_comb begin
        pk_emax = dbl ? 13'sd2047 : 13'sd255;
        pk_ovf  = 1'b0;
        pk_inv  = 1'b0;
        pk_res  = '0;
        if (spec_vld) begin
            pk_res = spec_res;
            pk_inv = spec_inv;
        end else if (r_zero) begin
            pk_res = '0;
        end else if (r_exp >= pk_emax) begin
            pk_res = inf_of(r_sign, dbl);
            pk_ovf = 1'b1;
        end else if (r_exp <= 13'sd0) begin
            pk_res = {r_sign, 63'b0};
        end else if (dbl) begin
            pk_res = {r_sign, r_exp[10:0], r_frac};
        end else begin
            pk_res = {r_sign, r_exp[7:0], r_frac[51:29], 32'b0};
        end
    end

    // ---------------- control + pipeline registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            overflow     <= 1'b0;
            invalid      <= 1'b0;
            write_data_f <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (op == FP_OP) && ((cop == COP_S) || (cop == COP_D)) &&
                        ((funct == FUNCT_ADD) || (funct == FUNCT_SUB))) begin
                        a_raw <= read_f_data1;
                        b_raw <= read_f_data2;
                        dbl   <= (cop == COP_D);
                        sub   <= (funct == FUNCT_SUB);
                        busy  <= 1'b1;
                        state <= UNPACK;
                    end
                end
                UNPACK: begin
                    u_sa     <= c_sa;
                    u_sb     <= c_sb;
                    u_ea     <= c_ea;
                    u_eb     <= c_eb;
                    u_ma     <= c_za ? 53'd0 : {1'b1, c_fa};
                    u_mb     <= c_zb ? 53'd0 : {1'b1, c_fb};
                    spec_vld <= c_spec;
                    spec_inv <= c_inv;
                    spec_res <= c_res;
                    state    <= ALIGN;
                end
                ALIGN: begin
                    x_sign  <= al_swap ? u_sb : u_sa;
                    x_sub   <= u_sa ^ u_sb;
                    x_exp   <= al_swap ? u_eb : u_ea;
                    x_big   <= {al_mb, 3'b000};
                    x_small <= {al_shifted[55:1], al_shifted[0] | al_stk};
                    state   <= ADD;
                end
                ADD: begin
                    s_sign <= x_sign;
                    s_exp  <= x_exp;
                    s_sum  <= x_sub ? ({1'b0, x_big} - {1'b0, x_small})
                                    : ({1'b0, x_big} + {1'b0, x_small});
                    state  <= NORM;
                end
                NORM: begin
                    n_sign <= s_sign;
                    n_zero <= (s_sum == '0);
                    if (s_sum[56]) begin
                        n_mant <= {s_sum[56:2], s_sum[1] | s_sum[0]};
                        n_exp  <= $signed({2'b00, s_exp}) + 13'sd1;
                    end else begin
                        n_mant <= nz_shifted;
                        n_exp  <= $signed({2'b00, s_exp}) - $signed({7'b0, nz_lz});
                    end
                    state <= ROUND;
                end
                ROUND: begin
                    r_sign <= n_sign;
                    r_zero <= n_zero;
                    if (rd_sum[53]) begin
                        r_frac <= rd_sum[52:1];
                        r_exp  <= n_exp + 13'sd1;
                    end else begin
                        r_frac <= rd_sum[51:0];
                        r_exp  <= n_exp;
                    end
                    state <= PACK;
                end
                PACK: begin
                    write_data_f <= pk_res;
                    overflow     <= pk_ovf;
                    invalid      <= pk_inv;
                    done         <= 1'b1;
                    state        <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_addsub_unit.sv
// Directed bench for fp_addsub_unit: expected results queued at issue, popped at done.
module tb_fp_addsub_unit;

    localparam logic [5:0] OP_FP = 6'b111111;
    localparam logic [4:0] CS    = 5'b10000;
    localparam logic [4:0] CD    = 5'b10001;
    localparam logic [5:0] FADD  = 6'b000000;
    localparam logic [5:0] FSUB  = 6'b000001;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [5:0]  op, funct;
    logic [4:0]  cop;
    logic [63:0] a, b;
    logic        busy, done, overflow, invalid;
    logic [63:0] write_data_f;

    always #5 clk = ~clk;

    fp_addsub_unit #(
        .FP_OP(OP_FP), .COP_S(CS), .COP_D(CD), .FUNCT_ADD(FADD), .FUNCT_SUB(FSUB)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .cop(cop), .funct(funct),
        .read_f_data1(a), .read_f_data2(b), .busy(busy), .done(done),
        .write_data_f(write_data_f), .overflow(overflow), .invalid(invalid)
    );

    typedef struct {
        string       tag;
        logic [63:0] res;
        logic        ovf;
        logic        inv;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_eval = 0;
    int unsigned n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_eval++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Drive one request for one edge, then scramble operands to prove they were captured.
    task automatic issue(input logic [4:0] c, input logic [5:0] f, input logic [63:0] x, input logic [63:0] y);
        @(negedge clk);
        op = OP_FP; cop = c; funct = f; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
    endtask

    // Count edges after the accept edge until done; 0 means it never came.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run(input string tag, input logic [4:0] c, input logic [5:0] f,
                       input logic [63:0] x, input logic [63:0] y,
                       input logic [63:0] er, input logic eo, input logic ei);
        exp_t e;
        int   lat;
        e.tag = tag; e.res = er; e.ovf = eo; e.inv = ei;
        sb.push_back(e);
        issue(c, f, x, y);
        wait_done(lat);
        chk({tag, "_latency"}, 64'(lat), 64'd6);
        if (lat != 0) begin
            e = sb.pop_front();
            chk({e.tag, "_result"}, write_data_f, e.res);
            chk({e.tag, "_overflow"}, 64'(overflow), 64'(e.ovf));
            chk({e.tag, "_invalid"}, 64'(invalid), 64'(e.inv));
            chk({e.tag, "_busy_at_done"}, 64'(busy), 64'd1);
            @(posedge clk); #1;
            chk({e.tag, "_done_one_cycle"}, 64'(done), 64'd0);
            chk({e.tag, "_busy_after"}, 64'(busy), 64'd0);
        end else begin
            void'(sb.pop_front());
        end
    endtask

    initial begin
        int pulses;
        int lat;
        exp_t e;

        rst = 1'b1; start = 1'b0; op = '0; cop = '0; funct = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_overflow", 64'(overflow), 64'd0);
        chk("reset_invalid", 64'(invalid), 64'd0);
        chk("reset_data", write_data_f, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run("s_add_1_2", CS, FADD, 64'h3F800000_DEADBEEF, 64'h40000000_12345678, 64'h40400000_00000000, 1'b0, 1'b0);
        run("d_sub_cancel", CD, FSUB, 64'h3FF8000000000000, 64'h3FF8000000000000, 64'h0, 1'b0, 1'b0);
        run("s_tie_even", CS, FADD, 64'h3F800000_00000000, 64'h33800000_00000000, 64'h3F800000_00000000, 1'b0, 1'b0);
        run("s_tie_odd", CS, FADD, 64'h3F800001_00000000, 64'h33800000_00000000, 64'h3F800002_00000000, 1'b0, 1'b0);
        run("d_overflow", CD, FADD, 64'h7FEFFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF, 64'h7FF0000000000000, 1'b1, 1'b0);
        run("s_inf_minus_inf", CS, FSUB, 64'h7F800000_00000000, 64'h7F800000_00000000, 64'h7FC00000_00000000, 1'b0, 1'b1);
        run("s_nan_in", CS, FADD, 64'h7FC00001_00000000, 64'h3F800000_00000000, 64'h7FC00000_00000000, 1'b0, 1'b1);
        run("d_add_1_2", CD, FADD, 64'h3FF0000000000000, 64'h4000000000000000, 64'h4008000000000000, 1'b0, 1'b0);
        run("s_sub_1_half", CS, FSUB, 64'h3F800000_00000000, 64'h3F000000_00000000, 64'h3F000000_00000000, 1'b0, 1'b0);
        run("s_negzero_sum", CS, FADD, 64'h80000000_00000000, 64'h80000000_00000000, 64'h80000000_00000000, 1'b0, 1'b0);
        run("d_inf_plus_1", CD, FADD, 64'h7FF0000000000000, 64'h3FF0000000000000, 64'h7FF0000000000000, 1'b0, 1'b0);

        // invalid precision: no accept, previous result held
        @(negedge clk);
        op = OP_FP; cop = 5'b10100; funct = FADD; a = 64'h3FF0000000000000; b = a; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("bad_cop_busy", 64'(busy), 64'd0);
        chk("bad_cop_hold", write_data_f, 64'h7FF0000000000000);

        // start while busy is ignored
        e.tag = "busy_start"; e.res = 64'h40400000_00000000; e.ovf = 1'b0; e.inv = 1'b0;
        sb.push_back(e);
        issue(CS, FADD, 64'h3F800000_00000000, 64'h40000000_00000000);
        op = OP_FP; cop = CD; funct = FSUB; a = 64'h4000000000000000; b = 64'h3FF0000000000000; start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        lat = 0;
        for (int i = 4; i <= 16; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
        chk("busy_start_latency", 64'(lat), 64'd6);
        e = sb.pop_front();
        chk({e.tag, "_result"}, write_data_f, e.res);
        pulses = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done === 1'b1) pulses++;
        end
        chk("busy_start_no_second_done", 64'(pulses), 64'd0);

        // reset while in ROUND aborts the operation
        issue(CD, FADD, 64'h3FF0000000000000, 64'h4000000000000000);
        repeat (4) @(negedge clk);
        chk("pre_abort_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_data", write_data_f, 64'd0);
        pulses = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done === 1'b1) pulses++;
        end
        chk("abort_no_done", 64'(pulses), 64'd0);

        run("post_abort_d_add", CD, FADD, 64'h3FF0000000000000, 64'h4000000000000000, 64'h4008000000000000, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end

endmodule
